// File: rtl/uart_fifo_sequencer.sv
// uart_fifo_sequencer: turns FCR field edges into single-cycle RX/TX FIFO
// clear strobes, tracks RX/TX occupancy, and produces the RX trigger-level,
// character-timeout and sticky overrun indications.
module uart_fifo_sequencer #(
    parameter int DEPTH    = 16,
    parameter int TO_CHARS = 4
) (
    input  logic                     m_clk,
    input  logic                     reset,
    input  logic                     FIFOEN,
    input  logic                     RXCLR,
    input  logic                     TXCLR,
    input  logic [1:0]               RXFIFTL,
    input  logic                     rx_push,
    input  logic                     rx_pop,
    input  logic                     tx_push,
    input  logic                     tx_pop,
    input  logic                     char_tick,
    input  logic                     lsr_read,
    output logic                     rx_fifo_clr,
    output logic                     tx_fifo_clr,
    output logic [$clog2(DEPTH):0]   rx_count,
    output logic [$clog2(DEPTH):0]   tx_count,
    output logic                     rx_trig,
    output logic                     rx_timeout,
    output logic                     rx_overrun,
    output logic                     tx_empty,
    output logic                     busy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TO_CHARS + 1);

    typedef enum logic [1:0] {IDLE, CLEAR, SETTLE} state_t;

    state_t          state, state_nxt;
    logic            fifoen_q, rxclr_q, txclr_q;
    logic [1:0]      req;            // [0] = RX, [1] = TX
    logic [1:0]      clr_mask, clr_mask_nxt;
    logic [1:0]      pend_mask, pend_mask_nxt;
    logic            rx_hold, tx_hold;
    logic [CW-1:0]   cap, trig_lvl;
    logic [TW-1:0]   to_cnt;
    logic            rx_full, tx_full;

    // Previous FCR levels for edge detection.
    always_ff @(posedge m_clk or negedge reset) begin
        if (!reset) begin
            fifoen_q <= 1'b0;
            rxclr_q  <= 1'b0;
            txclr_q  <= 1'b0;
        end else begin
            fifoen_q <= FIFOEN;
            rxclr_q  <= RXCLR;
            txclr_q  <= TXCLR;
        end
    end

    // Any FIFOEN change clears both FIFOs; RXCLR/TXCLR rising edges clear one.
    always_comb begin
        req[0] = (RXCLR & ~rxclr_q) | (FIFOEN ^ fifoen_q);
        req[1] = (TXCLR & ~txclr_q) | (FIFOEN ^ fifoen_q);
    end

    // Sequencer state register, including active and pending clear masks.
    always_ff @(posedge m_clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            clr_mask  <= '0;
            pend_mask <= '0;
        end else begin
            state     <= state_nxt;
            clr_mask  <= clr_mask_nxt;
            pend_mask <= pend_mask_nxt;
        end
    end

    // Next state; requests seen while busy are merged and replayed from SETTLE.
    always_comb begin
        state_nxt     = state;
        clr_mask_nxt  = clr_mask;
        pend_mask_nxt = pend_mask;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt    = CLEAR;
                    clr_mask_nxt = req;
                end
            end
            CLEAR: begin
                state_nxt     = SETTLE;
                pend_mask_nxt = pend_mask | req;
            end
            SETTLE: begin
                if (|(pend_mask | req)) begin
                    state_nxt    = CLEAR;
                    clr_mask_nxt = pend_mask | req;
                end else begin
                    state_nxt    = IDLE;
                    clr_mask_nxt = '0;
                end
                pend_mask_nxt = '0;
            end
            default: begin
                state_nxt     = IDLE;
                clr_mask_nxt  = '0;
                pend_mask_nxt = '0;
            end
        endcase
    end

    // Strobes, busy and per-FIFO freeze derived from the sequencer state.
    always_comb begin
        rx_fifo_clr = (state == CLEAR) & clr_mask[0];
        tx_fifo_clr = (state == CLEAR) & clr_mask[1];
        rx_hold     = (state != IDLE) & clr_mask[0];
        tx_hold     = (state != IDLE) & clr_mask[1];
        busy        = (state != IDLE);
    end

    // Capacity and trigger level depend on FIFO vs character mode.
    always_comb begin
        cap      = FIFOEN ? CW'(DEPTH) : CW'(1);
        trig_lvl = CW'(1);
        if (FIFOEN) begin
            case (RXFIFTL)
                2'b00:   trig_lvl = CW'(1);
                2'b01:   trig_lvl = CW'(DEPTH / 4);
                2'b10:   trig_lvl = CW'(DEPTH / 2);
                default: trig_lvl = CW'(DEPTH - 2);
            endcase
        end
        rx_full    = (rx_count >= cap);
        tx_full    = (tx_count >= cap);
        rx_trig    = (rx_count >= trig_lvl);
        tx_empty   = (tx_count == '0);
        rx_timeout = FIFOEN & (to_cnt == TW'(TO_CHARS)) & (rx_count != '0);
    end

    // RX occupancy; a frozen FIFO is held at zero through CLEAR and SETTLE.
    always_ff @(posedge m_clk or negedge reset) begin
        if (!reset) begin
            rx_count <= '0;
        end else if (rx_hold) begin
            rx_count <= '0;
        end else if (rx_push & ~rx_pop & ~rx_full) begin
            rx_count <= rx_count + 1'b1;
        end else if (rx_pop & ~rx_push & (rx_count != '0)) begin
            rx_count <= rx_count - 1'b1;
        end
    end

    // TX occupancy, same rules as RX.
    always_ff @(posedge m_clk or negedge reset) begin
        if (!reset) begin
            tx_count <= '0;
        end else if (tx_hold) begin
            tx_count <= '0;
        end else if (tx_push & ~tx_pop & ~tx_full) begin
            tx_count <= tx_count + 1'b1;
        end else if (tx_pop & ~tx_push & (tx_count != '0)) begin
            tx_count <= tx_count - 1'b1;
        end
    end

    // Sticky overrun: a lone push into a full RX FIFO; set beats lsr_read.
    always_ff @(posedge m_clk or negedge reset) begin
        if (!reset) begin
            rx_overrun <= 1'b0;
        end else if (~rx_hold & rx_push & ~rx_pop & rx_full) begin
            rx_overrun <= 1'b1;
        end else if (lsr_read) begin
            rx_overrun <= 1'b0;
        end
    end

    // Character-timeout counter, saturating at TO_CHARS.
    always_ff @(posedge m_clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (rx_hold | rx_push | rx_pop) begin
            to_cnt <= '0;
        end else if (FIFOEN & char_tick & (rx_count != '0) & (to_cnt != TW'(TO_CHARS))) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

endmodule
